// File: rtl/padding_window_reader.sv
// padding_window_reader: latches one padded row triple (R/G/B x rows 0..2)
// and streams IMG_W 3x3x3 windows, one per output column, with row tracking.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   row_valid/row_ready padded row triple handshake (accepted only in IDLE)
//   {R,G,B}_row{0,1,2}  padded rows, pixel i at [i*PIX_W +: PIX_W], i=0 left pad
//   win_valid/win_ready window handshake toward the conv array
//   win_R/G/B           3x3 window, tap (r,k) at [(3r+k)*PIX_W +: PIX_W]
//   win_col, win_row    position of the current window in the frame
//   win_last            last column of the row
//   frame_last          last column of the last row of the frame
module padding_window_reader #(
    parameter int IMG_W = 416,
    parameter int IMG_H = 416,
    parameter int PIX_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           row_valid,
    output logic                           row_ready,
    input  logic [(IMG_W+2)*PIX_W-1:0]     R_row0,
    input  logic [(IMG_W+2)*PIX_W-1:0]     G_row0,
    input  logic [(IMG_W+2)*PIX_W-1:0]     B_row0,
    input  logic [(IMG_W+2)*PIX_W-1:0]     R_row1,
    input  logic [(IMG_W+2)*PIX_W-1:0]     G_row1,
    input  logic [(IMG_W+2)*PIX_W-1:0]     B_row1,
    input  logic [(IMG_W+2)*PIX_W-1:0]     R_row2,
    input  logic [(IMG_W+2)*PIX_W-1:0]     G_row2,
    input  logic [(IMG_W+2)*PIX_W-1:0]     B_row2,
    output logic                           win_valid,
    input  logic                           win_ready,
    output logic [9*PIX_W-1:0]             win_R,
    output logic [9*PIX_W-1:0]             win_G,
    output logic [9*PIX_W-1:0]             win_B,
    output logic [$clog2(IMG_W)-1:0]       win_col,
    output logic [$clog2(IMG_H)-1:0]       win_row,
    output logic                           win_last,
    output logic                           frame_last
);

    localparam int RW = (IMG_W + 2) * PIX_W;
    localparam int CW = $clog2(IMG_W);
    localparam int HW = $clog2(IMG_H);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_col;
    logic [HW-1:0] r_row;
    logic [RW-1:0] r_R [3];
    logic [RW-1:0] r_G [3];
    logic [RW-1:0] r_B [3];

    logic w_take;
    logic w_fire;
    logic w_col_end;
    logic w_row_end;

    assign w_take    = (r_state == S_IDLE) && row_valid;
    assign w_fire    = (r_state == S_STREAM) && win_ready;
    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_row_end = (r_row == HW'(IMG_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            for (int i = 0; i < 3; i++) begin
                r_R[i] <= '0;
                r_G[i] <= '0;
                r_B[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_R[0]  <= R_row0;
                        r_R[1]  <= R_row1;
                        r_R[2]  <= R_row2;
                        r_G[0]  <= G_row0;
                        r_G[1]  <= G_row1;
                        r_G[2]  <= G_row2;
                        r_B[0]  <= B_row0;
                        r_B[1]  <= B_row1;
                        r_B[2]  <= B_row2;
                        r_col   <= '0;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_fire) begin
                        if (w_col_end) begin
                            r_state <= S_IDLE;
                            r_row   <= w_row_end ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Window for column c is padded columns c..c+2; a pure mux on latched rows.
    always_comb begin
        win_R = '0;
        win_G = '0;
        win_B = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                win_R[(3*r+k)*PIX_W +: PIX_W] =
                    r_R[r][(int'(r_col)+k)*PIX_W +: PIX_W];
                win_G[(3*r+k)*PIX_W +: PIX_W] =
                    r_G[r][(int'(r_col)+k)*PIX_W +: PIX_W];
                win_B[(3*r+k)*PIX_W +: PIX_W] =
                    r_B[r][(int'(r_col)+k)*PIX_W +: PIX_W];
            end
        end
    end

    assign row_ready  = (r_state == S_IDLE);
    assign win_valid  = (r_state == S_STREAM);
    assign win_col    = r_col;
    assign win_row    = r_row;
    assign win_last   = win_valid && w_col_end;
    assign frame_last = win_last && w_row_end;

endmodule
